lut_layer_sched: RTL and testbench

// - Time-multiplexes one shared neuron truth-table memory (synchronous read, 1-cycle latency) across N_NEURONS LUT neurons of a layer.
// - Accepts one gathered input vector per transaction and issues one table read per neuron.
// - Collects the per-neuron outputs into one result word.
// - Also arbitrates runtime table writes (cfg port) against evaluation.
// - Sits between the layer input gather and the next layer in the LUT network pipeline.

---
 rtl/lut_layer_sched_if.sv | 39 +++
 rtl/lut_layer_sched.sv | 130 +++++++++++++
 tb/tb_lut_layer_sched.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_layer_sched_if.sv
// Bundle of the input-vector, result, table-config and table-memory signals
// for lut_layer_sched.
//   s_*   : gathered input vector stream (valid/ready)
//   m_*   : collected result word stream (valid/ready)
//   cfg_* : runtime table write requests (valid/ready)
//   lut_* : shared truth-table memory port (sync read, 1-cycle latency)
// slave modport is the scheduler's view; master is the surrounding logic.
interface lut_layer_sched_if #(
  parameter int N_NEURONS = 4,
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 2,
  parameter int IDX_W     = $clog2(N_NEURONS)
);
  logic                          s_valid;
  logic                          s_ready;
  logic [N_NEURONS*IN_BITS-1:0]  s_data;
  logic                          m_valid;
  logic                          m_ready;
  logic [N_NEURONS*OUT_BITS-1:0] m_data;
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [IDX_W+IN_BITS-1:0]      cfg_addr;
  logic [OUT_BITS-1:0]           cfg_wdata;
  logic                          lut_en;
  logic                          lut_we;
  logic [IDX_W+IN_BITS-1:0]      lut_addr;
  logic [OUT_BITS-1:0]           lut_wdata;
  logic [OUT_BITS-1:0]           lut_rdata;

  modport slave (
    input  s_valid, s_data, m_ready, cfg_valid, cfg_addr, cfg_wdata, lut_rdata,
    output s_ready, m_valid, m_data, cfg_ready, lut_en, lut_we, lut_addr, lut_wdata
  );

  modport master (
    output s_valid, s_data, m_ready, cfg_valid, cfg_addr, cfg_wdata, lut_rdata,
    input  s_ready, m_valid, m_data, cfg_ready, lut_en, lut_we, lut_addr, lut_wdata
  );
endinterface

// File: rtl/lut_layer_sched.sv
// Time-multiplexes one shared neuron truth-table memory across N_NEURONS LUT
// neurons: accepts one gathered input vector, issues one table read per
// neuron, collects the per-neuron outputs into one result word, and lets
// runtime table writes through while idle.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : lut_layer_sched_if.slave (s_*, m_*, cfg_*, lut_* signals)
//   stall_cnt : [15:0] saturating count of cycles with m_valid && !m_ready,
//               present only when LUTSCHED_STALL_CNT_EN is defined
module lut_layer_sched #(
  parameter int N_NEURONS = 4,
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 2,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst,
  lut_layer_sched_if.slave        bus
`ifdef LUTSCHED_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic                          pend_q;
  logic [IDX_W-1:0]              pend_idx_q;
  logic [N_NEURONS*IN_BITS-1:0]  s_buf_q;
  logic [N_NEURONS*OUT_BITS-1:0] m_data_q;
  logic [IN_BITS-1:0]            rd_entry;
  logic                          accept;

  // Neuron idx_q's table entry from the captured vector.
  always_comb begin
    rd_entry = '0;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      if (idx_q == IDX_W'(i)) rd_entry = s_buf_q[i*IN_BITS +: IN_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    accept        = 1'b0;
    bus.s_ready   = 1'b0;
    bus.cfg_ready = 1'b0;
    bus.lut_en    = 1'b0;
    bus.lut_we    = 1'b0;
    bus.lut_addr  = '0;
    bus.lut_wdata = '0;
    unique case (state_q)
      IDLE: begin
        // Table writes win over a simultaneous input vector.
        bus.cfg_ready = 1'b1;
        bus.s_ready   = !bus.cfg_valid;
        if (bus.cfg_valid) begin
          bus.lut_we    = 1'b1;
          bus.lut_addr  = bus.cfg_addr;
          bus.lut_wdata = bus.cfg_wdata;
        end else if (bus.s_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.lut_en   = 1'b1;
        bus.lut_addr = {idx_q, rd_entry};
        idx_d        = IDX_W'(idx_q + 1'b1);
        if (idx_q == IDX_W'(N_NEURONS - 1)) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE:  if (bus.m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lands one cycle after each strobe; the pending flag/index
  // travel alongside so the last read is still collected during DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      s_buf_q    <= '0;
      m_data_q   <= '0;
    end else begin
      pend_q     <= bus.lut_en;
      pend_idx_q <= idx_q;
      if (accept) begin
        s_buf_q  <= bus.s_data;
        m_data_q <= '0;
      end else if (pend_q) begin
        for (int unsigned i = 0; i < N_NEURONS; i++) begin
          if (pend_idx_q == IDX_W'(i)) m_data_q[i*OUT_BITS +: OUT_BITS] <= bus.lut_rdata;
        end
      end
    end
  end

  assign bus.m_valid = (state_q == DONE);
  assign bus.m_data  = m_data_q;

`ifdef LUTSCHED_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bus.m_valid && !bus.m_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_lut_layer_sched.sv
module tb_lut_layer_sched;

  localparam int NN = 4;
  localparam int IB = 8;
  localparam int OB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mr_mode = 1;  // 0: m_ready low, 1: high, 2: random

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lut_layer_sched_if #(.N_NEURONS(NN), .IN_BITS(IB), .OUT_BITS(OB)) bus ();

`ifdef LUTSCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  lut_layer_sched #(.N_NEURONS(NN), .IN_BITS(IB), .OUT_BITS(OB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef LUTSCHED_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Table memory with synchronous 1-cycle read.
  logic [OB-1:0] mem [NN][256];
  initial begin
    for (int i = 0; i < NN; i++)
      for (int a = 0; a < 256; a++) mem[i][a] = OB'((a + i) % 4);
    bus.lut_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.lut_we) mem[bus.lut_addr[9:8]][bus.lut_addr[7:0]] <= bus.lut_wdata;
      if (bus.lut_en) bus.lut_rdata <= mem[bus.lut_addr[9:8]][bus.lut_addr[7:0]];
    end
  end

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mr_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference: result = per-neuron lookup of a shadow table that follows
  // every accepted cfg write.
  logic [OB-1:0] ref_tbl [NN][256];

  function automatic logic [NN*OB-1:0] model(input logic [NN*IB-1:0] d);
    logic [NN*OB-1:0] r;
    r = '0;
    for (int i = 0; i < NN; i++) r[i*OB +: OB] = ref_tbl[i][d[i*IB +: IB]];
    return r;
  endfunction

  typedef struct { logic [NN*OB-1:0] exp; int acc; } sb_t;
  sb_t  sb [$];
  logic [9:0] rd_log [$];

  // Monitor / scoreboard.
  initial begin
    logic prev_mv;
    prev_mv = 1'b0;
    for (int i = 0; i < NN; i++)
      for (int a = 0; a < 256; a++) ref_tbl[i][a] = OB'((a + i) % 4);
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        prev_mv = 1'b0;
      end else begin
        if (bus.lut_en) rd_log.push_back(bus.lut_addr);
        if (!bus.lut_en && !bus.lut_we)
          chk("idle_lut_bus", {22'd0, bus.lut_addr}, 32'd0 | {30'd0, bus.lut_wdata});
        if (bus.cfg_valid && bus.cfg_ready)
          ref_tbl[bus.cfg_addr[9:8]][bus.cfg_addr[7:0]] = bus.cfg_wdata;
        if (bus.m_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0h expected none", bus.m_data);
          end else begin
            if (!prev_mv) chk("latency", cyc - (sb[0].acc + 1), 5);
            chk("m_data", bus.m_data, sb[0].exp);
            chk("s_ready_in_done", bus.s_ready, 0);
            if (bus.m_ready) void'(sb.pop_front());
          end
        end
        if (bus.s_valid && bus.s_ready) sb.push_back('{exp: model(bus.s_data), acc: cyc});
        prev_mv = bus.m_valid;
      end
    end
  end

  task automatic send(input logic [NN*IB-1:0] d, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        acc = cyc;
        ok  = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [9:0] a, input logic [1:0] w);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = w;
    @(negedge clk);
    chk("cfg_ready", bus.cfg_ready, 1);
    chk("cfg_lut_we", bus.lut_we, 1);
    chk("cfg_lut_addr", bus.lut_addr, a);
    chk("cfg_lut_wdata", bus.lut_wdata, w);
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int accs [$];
    logic [NN*IB-1:0] d;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_lut_en", bus.lut_en, 0);
    chk("rst_lut_we", bus.lut_we, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_m_data", bus.m_data, 0);
`ifdef LUTSCHED_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif

    // Basic transaction and read address order.
    rd_log.delete();
    send({8'd3, 8'd2, 8'd1, 8'd0}, acc);
    wait_idle();
    chk("rd_count", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++)
      chk("rd_addr", rd_log[i], (i << 8) | i);

    // Backpressure: m_ready low for 10 cycles with a new vector waiting.
    mr_mode = 0;
    send(32'h1234_5678, acc);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (bus.m_valid) begin
          seen = 1'b1;
          break;
        end
      end
      chk("bp_m_valid_timeout", seen, 1);
    end
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) begin
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h9abc_def0;
      end
      chk("bp_s_ready", bus.s_ready, 0);
      chk("bp_m_valid", bus.m_valid, 1);
    end
`ifdef LUTSCHED_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 10);
`endif
    mr_mode = 1;
    send(32'h9abc_def0, acc);
    wait_idle();

    // Cfg priority over a simultaneous input vector.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h0000_0500;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = {2'd1, 8'h05};
    bus.cfg_wdata = 2'b11;
    @(negedge clk);
    chk("prio_s_ready", bus.s_ready, 0);
    chk("prio_lut_we", bus.lut_we, 1);
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    send(32'h0000_0500, acc);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (bus.m_valid) begin
          seen = 1'b1;
          chk("prio_neuron1", bus.m_data[3:2], 2'b11);
          break;
        end
      end
      chk("prio_result_timeout", seen, 1);
    end
    wait_idle();

    // Reset after the second read.
    send(32'hffee_ddcc, acc);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_lut_en", bus.lut_en, 0);
    chk("midrst_s_ready", bus.s_ready, 1);
    send(32'h0102_0304, acc);
    wait_idle();

    // Back-to-back random vectors with exact spacing.
    accs.delete();
    for (int k = 0; k < 20; k++) begin
      d = $urandom;
      send(d, acc);
      accs.push_back(acc);
    end
    for (int k = 1; k < 20; k++) chk("spacing", accs[k] - accs[k-1], 7);
    wait_idle();

    // Random cfg writes interleaved with random m_ready.
    mr_mode = 2;
    for (int k = 0; k < 15; k++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) cfg_write(10'($urandom), 2'($urandom));
      d = $urandom;
      if (k % 3 == 0) d[15:8] = 8'h05;
      send(d, acc);
      wait_idle();
    end
    mr_mode = 1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
